// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register indices, per-source state encoding and limits for irq_ctrl.
package irq_ctrl_pkg;
    localparam logic [1:0] REG_PENDING   = 2'd0;
    localparam logic [1:0] REG_ENABLE    = 2'd1;
    localparam logic [1:0] REG_CLAIM     = 2'd2;
    localparam logic [1:0] REG_INSERVICE = 2'd3;
    localparam int MAX_SOURCES = 31;
    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        IN_SERVICE
    } src_state_e;
endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_ctrl_prio_enc: lowest-set-bit encoder; the lowest requesting index wins.
module irq_ctrl_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [4:0]   idx_o
);
    always_comb begin
        idx_o = 5'd0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = 5'(i);
        valid_o = |req_i;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-source claim/complete FSMs.
// Define IRQ_CTRL_SYNC_EN to pass each irqSrc bit through a 2-flop synchronizer.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [NUM_SOURCES-1:0] irqSrc,
    output logic                   irq,
    output logic [31:0]            readData,
    input  logic [3:0]             addr,
    input  logic [31:0]            writeData,
    input  logic                   readEnable,
    input  logic                   writeEnable
);
    logic [NUM_SOURCES-1:0] src;
`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irqSrc;
            sync2_q <= sync1_q;
        end
    end
    assign src = sync2_q;
`else
    assign src = irqSrc;
`endif
    src_state_e             state_q [NUM_SOURCES];
    src_state_e             state_d [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] enable_q, enable_d, pending, in_service;
    logic                   cand_valid, claim_fire, complete;
    logic [4:0]             cand_idx, claim_id, cmp_id;
    logic [1:0]             sel;
    logic                   unused_bits;

    assign sel         = addr[3:2];
    assign cmp_id      = writeData[4:0];
    assign unused_bits = ^{addr[1:0], writeData};

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            pending[i]    = state_q[i] == PENDING;
            in_service[i] = state_q[i] == IN_SERVICE;
        end
    end

    irq_ctrl_prio_enc #(.N(NUM_SOURCES)) u_prio (
        .req_i   (pending & enable_q),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    assign claim_id = cand_valid ? cand_idx + 5'd1 : 5'd0;
    assign irq      = cand_valid;
    // A concurrent write suppresses the claim side effect of a read.
    assign claim_fire = readEnable && !writeEnable && sel == REG_CLAIM && cand_valid;
    assign complete   = writeEnable && sel == REG_CLAIM;

    assign readData = sel == REG_PENDING ? 32'(pending)  :
                      sel == REG_ENABLE  ? 32'(enable_q) :
                      sel == REG_CLAIM   ? 32'(claim_id) : 32'(in_service);

    // Matching cmp_id against i+1 for i < NUM_SOURCES rejects IDs 0 and > NUM_SOURCES.
    always_comb begin
        enable_d = (writeEnable && sel == REG_ENABLE) ? writeData[NUM_SOURCES-1:0] : enable_q;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:       if (src[i]) state_d[i] = PENDING;
                PENDING:    if (claim_fire && cand_idx == 5'(i)) state_d[i] = IN_SERVICE;
                IN_SERVICE: if (complete && cmp_id == 5'(i + 1)) state_d[i] = IDLE;
                default:    state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            enable_q <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) state_q[i] <= IDLE;
        end else begin
            enable_q <= enable_d;
            state_q  <= state_d;
        end
    end
endmodule
